// File: rtl/rv_multicycle_ctrl_if.sv
// rtl/rv_multicycle_ctrl_if.sv - instruction/data memory req/ack handshake bundle
interface rv_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - RV32I multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer
// Optional memory-handshake timeout trap enabled by defining CTRL_TIMEOUT_EN.
module rv_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  rv_multicycle_ctrl_if.master  mem,
  input  logic [6:0]            opcode_in,
  input  logic                  branch_taken_in,
  output logic                  ir_we,
  output logic                  alu_en,
  output logic                  rf_we,
  output logic [1:0]            wb_sel,
  output logic                  pc_we,
  output logic [1:0]            pc_sel,
  output logic                  retire_out,
  output logic                  trap_out,
  output logic [1:0]            trap_cause_out,
  output logic [2:0]            state_out
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  state_t     state, state_nxt;
  logic       trap_q;
  logic [1:0] cause_q;
  logic       trap_set;
  logic [1:0] trap_cause_nxt;
  logic       timeout;

  logic imem_req_c, dmem_req_c, dmem_we_c;
  logic ir_we_c, alu_en_c, rf_we_c, pc_we_c, retire_c;
  logic [1:0] wb_sel_c, pc_sel_c;

  logic is_legal, is_branch, is_load, is_store, is_jal, is_jalr, is_lui;

  always_comb begin
    is_branch = (opcode_in == OP_BRANCH);
    is_load   = (opcode_in == OP_LOAD);
    is_store  = (opcode_in == OP_STORE);
    is_jal    = (opcode_in == OP_JAL);
    is_jalr   = (opcode_in == OP_JALR);
    is_lui    = (opcode_in == OP_LUI);
    is_legal  = is_branch || is_load || is_store || is_jal || is_jalr || is_lui ||
                (opcode_in == OP_R) || (opcode_in == OP_I) || (opcode_in == OP_AUIPC);
  end

`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = ((state == S_FETCH) && !mem.imem_ack) ||
                   ((state == S_MEM)   && !mem.dmem_ack);
  assign timeout = (wait_cnt >= CNT_W'(TIMEOUT_CYCLES));

  // Only FETCH and MEM wait, so clearing on any state change covers entry to both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else if (trap_set) begin
      trap_q  <= 1'b1;
      cause_q <= trap_cause_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    imem_req_c     = 1'b0;
    dmem_req_c     = 1'b0;
    dmem_we_c      = 1'b0;
    ir_we_c        = 1'b0;
    alu_en_c       = 1'b0;
    rf_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    retire_c       = 1'b0;
    wb_sel_c       = WB_ALU;
    pc_sel_c       = PC_PLUS4;
    trap_set       = 1'b0;
    trap_cause_nxt = 2'd0;
    unique case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          ir_we_c   = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          state_nxt      = S_TRAP;
          trap_set       = 1'b1;
          trap_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_nxt = S_EXECUTE;
        end else begin
          state_nxt      = S_TRAP;
          trap_set       = 1'b1;
          trap_cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        alu_en_c = 1'b1;
        if (is_branch) begin
          pc_we_c   = 1'b1;
          pc_sel_c  = branch_taken_in ? PC_IMM : PC_PLUS4;
          retire_c  = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (mem.dmem_ack) begin
          if (is_store) begin
            pc_we_c   = 1'b1;
            retire_c  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timeout) begin
          state_nxt      = S_TRAP;
          trap_set       = 1'b1;
          trap_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        retire_c  = 1'b1;
        state_nxt = S_FETCH;
        if (is_load) begin
          wb_sel_c = WB_MEM;
        end else if (is_jal) begin
          wb_sel_c = WB_PC4;
          pc_sel_c = PC_IMM;
        end else if (is_jalr) begin
          wb_sel_c = WB_PC4;
          pc_sel_c = PC_ALU;
        end else if (is_lui) begin
          wb_sel_c = WB_IMM;
        end
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Reset gates every strobe so an aborted instruction cannot write or retire.
  always_comb begin
    mem.imem_req   = imem_req_c & ~reset;
    mem.dmem_req   = dmem_req_c & ~reset;
    mem.dmem_we    = dmem_we_c  & ~reset;
    ir_we          = ir_we_c    & ~reset;
    alu_en         = alu_en_c   & ~reset;
    rf_we          = rf_we_c    & ~reset;
    pc_we          = pc_we_c    & ~reset;
    retire_out     = retire_c   & ~reset;
    wb_sel         = reset ? 2'd0 : wb_sel_c;
    pc_sel         = reset ? 2'd0 : pc_sel_c;
    trap_out       = trap_q & ~reset;
    trap_cause_out = reset ? 2'd0 : cause_q;
    state_out      = reset ? 3'd0 : state;
  end

endmodule
